// File: rtl/mpe_window_scheduler.sv
// Kernel-offset sequencer for the MPE window selector: row-major (kh, kw) sweep with valid/ready hand-off.
// Optional MPE_WEIGHT_SKIP_EN adds weight_zero_mask so zero-weight offsets are never issued.
`ifndef KERNEL_HEIGHT
`define KERNEL_HEIGHT 3
`endif
`ifndef KERNEL_WIDTH
`define KERNEL_WIDTH 3
`endif

module mpe_window_scheduler #(
    parameter int KERNEL_HEIGHT = `KERNEL_HEIGHT,
    parameter int KERNEL_WIDTH  = `KERNEL_WIDTH,
    localparam int KH_W  = (KERNEL_HEIGHT > 1) ? $clog2(KERNEL_HEIGHT) : 1,
    localparam int KW_W  = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1,
    localparam int CKH_W = $clog2(KERNEL_HEIGHT + 1),
    localparam int CKW_W = $clog2(KERNEL_WIDTH + 1),
    localparam int KN    = KERNEL_HEIGHT * KERNEL_WIDTH,
    localparam int CNT_W = $clog2(KN + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CKH_W-1:0] cfg_kh,
    input  logic [CKW_W-1:0] cfg_kw,
    input  logic [2:0]       cfg_stride,
`ifdef MPE_WEIGHT_SKIP_EN
    input  logic [KN-1:0]    weight_zero_mask,
`endif
    output logic [KH_W-1:0]  weight_height,
    output logic [KW_W-1:0]  weight_width,
    output logic [2:0]       stride,
    output logic             sel_valid,
    input  logic             sel_ready,
    output logic             sel_first,
    output logic             sel_last,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic            found;
        logic            more;
        logic [KH_W-1:0] h;
        logic [KW_W-1:0] w;
    } hit_t;

    state_t           state;
    logic [CKH_W-1:0] kh_q;
    logic [CKW_W-1:0] kw_q;
    logic [KN-1:0]    mask_q;
    logic [KN-1:0]    mask_in;
    logic             cfg_ok;
    logic             xfer;
    hit_t             h0;
    hit_t             hn;

    // First unmasked in-range offset at or after linear index 'from', and whether another one follows it.
    function automatic hit_t scan(input logic [KN-1:0] mask, input int from, input int kh_n, input int kw_n);
        hit_t r;
        r = '0;
        for (int h = 0; h < KERNEL_HEIGHT; h++) begin
            for (int w = 0; w < KERNEL_WIDTH; w++) begin
                if ((h * KERNEL_WIDTH + w >= from) && (h < kh_n) && (w < kw_n) && !mask[h * KERNEL_WIDTH + w]) begin
                    if (r.found) begin
                        r.more = 1'b1;
                    end else begin
                        r.found = 1'b1;
                        r.h     = h[KH_W-1:0];
                        r.w     = w[KW_W-1:0];
                    end
                end
            end
        end
        return r;
    endfunction

`ifdef MPE_WEIGHT_SKIP_EN
    assign mask_in = weight_zero_mask;
`else
    assign mask_in = '0;
`endif

    assign cfg_ok = (cfg_kh != '0) && (int'(cfg_kh) <= KERNEL_HEIGHT) &&
                    (cfg_kw != '0) && (int'(cfg_kw) <= KERNEL_WIDTH) && (cfg_stride != 3'd0);
    assign xfer   = sel_valid && sel_ready;

    always_comb begin
        h0 = scan(mask_in, 0, int'(cfg_kh), int'(cfg_kw));
        hn = scan(mask_q, int'(weight_height) * KERNEL_WIDTH + int'(weight_width) + 1, int'(kh_q), int'(kw_q));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            kh_q          <= '0;
            kw_q          <= '0;
            mask_q        <= '0;
            weight_height <= '0;
            weight_width  <= '0;
            stride        <= '0;
            sel_valid     <= 1'b0;
            sel_first     <= 1'b0;
            sel_last      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cfg_err       <= 1'b0;
            xfer_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        busy     <= 1'b1;
                        xfer_cnt <= '0;
                        if (!cfg_ok) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            cfg_err <= 1'b1;
                        end else begin
                            kh_q    <= cfg_kh;
                            kw_q    <= cfg_kw;
                            mask_q  <= mask_in;
                            stride  <= cfg_stride;
                            cfg_err <= 1'b0;
                            // A fully masked kernel has nothing to issue and finishes straight away.
                            if (h0.found) begin
                                state         <= RUN;
                                sel_valid     <= 1'b1;
                                weight_height <= h0.h;
                                weight_width  <= h0.w;
                                sel_first     <= 1'b1;
                                sel_last      <= !h0.more;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    if (xfer) xfer_cnt <= xfer_cnt + CNT_W'(1);
                    if (abort || (xfer && (sel_last || !hn.found))) begin
                        state         <= abort ? IDLE : DONE;
                        busy          <= !abort;
                        done          <= !abort;
                        sel_valid     <= 1'b0;
                        weight_height <= '0;
                        weight_width  <= '0;
                        sel_first     <= 1'b0;
                        sel_last      <= 1'b0;
                    end else if (xfer) begin
                        weight_height <= hn.h;
                        weight_width  <= hn.w;
                        sel_first     <= 1'b0;
                        sel_last      <= !hn.more;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
